// File: rtl/div_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : div_secuencial
//  Purpose  : Sequential WIDTH-bit integer divider. Produces the quotient and
//             the remainder by restoring division, one quotient bit per clock,
//             behind a start/done handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     inicio     in   1      start request, sampled only in IDLE
//     operando1  in   WIDTH  dividend
//     operando2  in   WIDTH  divisor
//     ocupado    out  1      high while a division is being iterated
//     listo      out  1      one-cycle pulse, results valid
//     cociente   out  WIDTH  quotient
//     residuo    out  WIDTH  remainder
//     div_cero   out  1      divisor of the last completed operation was 0
// ----------------------------------------------------------------------------
//  Configuration macro
//     DIV_SIGNED_EN  defined   : two's complement operands (magnitudes are
//                                divided, signs fixed up on the final edge)
//                    undefined : unsigned division, no sign logic
// ============================================================================
module div_secuencial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inicio,
   input  logic [WIDTH-1:0] operando1,
   input  logic [WIDTH-1:0] operando2,
   output logic             ocupado,
   output logic             listo,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] residuo,
   output logic             div_cero
);

   // Counter must be able to hold the value WIDTH itself.
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   quo_q,      quo_d;      // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]   rem_q,      rem_d;      // partial remainder
   logic [WIDTH-1:0]   dvs_q,      dvs_d;      // latched divisor (magnitude)
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [WIDTH-1:0]   cociente_q, cociente_d;
   logic [WIDTH-1:0]   residuo_q,  residuo_d;
   logic               div_cero_q, div_cero_d;
   logic               ocupado_q,  ocupado_d;
   logic               listo_q,    listo_d;

`ifdef DIV_SIGNED_EN
   logic               neg_quo_q,  neg_quo_d;  // operand signs differ
   logic               neg_rem_q,  neg_rem_d;  // dividend was negative
   logic               w_neg_a;
   logic               w_neg_b;
`endif

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_rem_sh;   // {remainder, dividend MSB} after the shift
   logic [WIDTH:0]     w_trial;    // trial subtraction at WIDTH+1 bits
   logic [WIDTH-1:0]   w_quo_step;
   logic [WIDTH-1:0]   w_rem_step;

   // ------------------------------------------------------------------------
   // Operand magnitudes presented at acceptance
   // ------------------------------------------------------------------------
   always_comb begin
`ifdef DIV_SIGNED_EN
      w_neg_a = operando1[WIDTH-1];
      w_neg_b = operando2[WIDTH-1];
      w_mag_a = w_neg_a ? (~operando1 + 1'b1) : operando1;
      w_mag_b = w_neg_b ? (~operando2 + 1'b1) : operando2;
`else
      w_mag_a = operando1;
      w_mag_b = operando2;
`endif
   end

   // ------------------------------------------------------------------------
   // One restoring step. The partial remainder is always below the divisor,
   // so after the shift it fits in WIDTH+1 bits and bit WIDTH of the
   // difference is a reliable sign.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rem_sh   = {rem_q, quo_q[WIDTH-1]};
      w_trial    = w_rem_sh - {1'b0, dvs_q};
      w_quo_step = {quo_q[WIDTH-2:0], ~w_trial[WIDTH]};
      w_rem_step = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      cociente_d = cociente_q;
      residuo_d  = residuo_q;
      div_cero_d = div_cero_q;
`ifdef DIV_SIGNED_EN
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
`endif

      case (state_q)
         IDLE: begin
            if (inicio) begin
               quo_d = w_mag_a;
               rem_d = '0;
               dvs_d = w_mag_b;
               cnt_d = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
               neg_quo_d = w_neg_a ^ w_neg_b;
               neg_rem_d = w_neg_a;
`endif
               if (operando2 == '0) begin
                  // Results are final on the accepting edge; remainder is
                  // the raw dividend, not its magnitude.
                  cociente_d = '1;
                  residuo_d  = operando1;
                  div_cero_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d    = CALC;
               end
            end
         end

         CALC: begin
            quo_d = w_quo_step;
            rem_d = w_rem_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
               cociente_d = neg_quo_q ? (~w_quo_step + 1'b1) : w_quo_step;
               residuo_d  = neg_rem_q ? (~w_rem_step + 1'b1) : w_rem_step;
`else
               cociente_d = w_quo_step;
               residuo_d  = w_rem_step;
`endif
               div_cero_d = 1'b0;
               state_d    = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the next state.
      ocupado_d = (state_d == CALC);
      listo_d   = (state_d == DONE);
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         cociente_q <= '0;
         residuo_q  <= '0;
         div_cero_q <= 1'b0;
         ocupado_q  <= 1'b0;
         listo_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         cociente_q <= cociente_d;
         residuo_q  <= residuo_d;
         div_cero_q <= div_cero_d;
         ocupado_q  <= ocupado_d;
         listo_q    <= listo_d;
`ifdef DIV_SIGNED_EN
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
`endif
      end
   end

   assign ocupado  = ocupado_q;
   assign listo    = listo_q;
   assign cociente = cociente_q;
   assign residuo  = residuo_q;
   assign div_cero = div_cero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_secuencial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_secuencial
//  Purpose  : Self-checking bench for div_secuencial. Directed cases plus
//             random operands, compared against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_secuencial;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             inicio;
   logic [WIDTH-1:0] operando1;
   logic [WIDTH-1:0] operando2;
   logic             ocupado;
   logic             listo;
   logic [WIDTH-1:0] cociente;
   logic [WIDTH-1:0] residuo;
   logic             div_cero;

   int n_tests = 0;
   int n_fail  = 0;

   div_secuencial #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inicio    (inicio),
      .operando1 (operando1),
      .operando2 (operando2),
      .ocupado   (ocupado),
      .listo     (listo),
      .cociente  (cociente),
      .residuo   (residuo),
      .div_cero  (div_cero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
      int sa, sb;
      sa = a;
      sb = b;
      dz = (b == 0);
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endtask

   // Issue one division; optionally re-pulse inicio (with new operands)
   // 'mid' cycles into the run, which must be ignored.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int mid);
      logic [31:0] eq, er;
      logic        ez;
      int          lat, busy;
      logic        got;
      model(a, b, eq, er, ez);
      @(negedge clk);
      operando1 = a;
      operando2 = b;
      inicio    = 1'b1;
      @(posedge clk);                 // accepting edge E0
      got  = 1'b0;
      lat  = -1;
      busy = 0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (listo) begin
            got = 1'b1;
            lat = j;
            break;
         end
         if (ocupado) busy++;
         if (j == 0) begin
            inicio    = 1'b0;
            operando1 = $urandom;
            operando2 = $urandom;
         end
         if (mid > 0 && j == mid) begin
            operando1 = 32'd9;
            operando2 = 32'd3;
            inicio    = 1'b1;
         end
         if (mid > 0 && j == mid + 1) inicio = 1'b0;
      end
      inicio = 1'b0;
      chk("listo_seen", {31'd0, got}, 32'd1);
      chk("latency",    lat,  (b == 0) ? 32'd0 : 32'd32);
      chk("busy_cycles", busy, (b == 0) ? 32'd0 : 32'd32);
      chk("cociente",   cociente, eq);
      chk("residuo",    residuo,  er);
      chk("div_cero",   {31'd0, div_cero}, {31'd0, ez});
      @(negedge clk);
      chk("listo_pulse", {31'd0, listo},   32'd0);
      chk("no_queue",    {31'd0, ocupado}, 32'd0);
      chk("hold_coc",    cociente, eq);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ocupado"},  {31'd0, ocupado},  32'd0);
      chk({tag, "_listo"},    {31'd0, listo},    32'd0);
      chk({tag, "_div_cero"}, {31'd0, div_cero}, 32'd0);
      chk({tag, "_cociente"}, cociente, 32'd0);
      chk({tag, "_residuo"},  residuo,  32'd0);
   endtask

   initial begin
      int pulses;
      logic [31:0] ra, rb;
      int sel;

      rst_n     = 1'b0;
      inicio    = 1'b0;
      operando1 = '0;
      operando2 = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("post_reset");

      do_div(32'd100, 32'd7, 0);
      do_div(32'hFFFF_FFFF, 32'd1, 0);
      do_div(32'd5, 32'd0, 0);
      do_div(32'd1000, 32'd3, 10);

      // Reset in the middle of a run: outputs clear at once, no listo later.
      @(negedge clk);
      operando1 = 32'd123456;
      operando2 = 32'd789;
      inicio    = 1'b1;
      @(negedge clk);
      inicio    = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (listo) pulses++;
      end
      chk("no_listo_after_rst", pulses, 32'd0);

      do_div(32'hFFFF_FFF9, 32'd2, 0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_div(32'd3, 32'd10, 0);
      do_div(32'h8000_0000, 32'd0, 0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         if (sel == 0)       rb = 32'd0;
         else if (sel < 5)   rb = $urandom_range(1, 255);
         else                rb = $urandom;
         if (sel == 9)       ra = $urandom_range(0, 1000);
         do_div(ra, rb, (sel == 3) ? 5 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
